// File: rtl/sha1_pkg.sv
// Shared constants, FSM encoding and byte-padding helper for the SHA-1 message padder.
package sha1_pkg;

  localparam int             SHA1_BLK_WORDS = 16;
  localparam int             SHA1_LEN_IDX   = 14;
  localparam logic [7:0]     SHA1_PAD_BYTE  = 8'h80;
  localparam logic [159:0]   SHA1_IV        = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    PAD    = 3'd2,
    LEN_HI = 3'd3,
    LEN_LO = 3'd4,
    SEND   = 3'd5,
    WAIT   = 3'd6
  } pad_state_t;

  // Keep the first `keep` bytes, place the pad marker right after them, zero the rest.
  function automatic logic [31:0] pad_last_word(input logic [31:0] d, input logic [1:0] keep);
    case (keep)
      2'd0:    return {SHA1_PAD_BYTE, 24'h0};
      2'd1:    return {d[31:24], SHA1_PAD_BYTE, 16'h0};
      2'd2:    return {d[31:16], SHA1_PAD_BYTE, 8'h0};
      default: return {d[31:8], SHA1_PAD_BYTE};
    endcase
  endfunction

endpackage

// File: rtl/sha1_blk_buf.sv
// 16x32 block staging buffer: one write port, one combinational read port.
module sha1_blk_buf
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  wptr,
  input  logic [31:0] wdata,
  input  logic [3:0]  rptr,
  output logic [31:0] rdata
);

  logic [SHA1_BLK_WORDS-1:0][31:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs message words into 16-word blocks, appends 0x80/zero/length,
// bursts blocks to the core and returns the digest. Optional raw (unpadded) mode: SHA1_PAD_RAW_EN.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef SHA1_PAD_RAW_EN
  input  logic         raw_mode,
`endif
  input  logic         msg_vld,
  output logic         msg_rdy,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_keep,
  output logic         core_din_vld,
  output logic [31:0]  core_din,
  output logic         core_use_prec_cv,
  input  logic         core_busy,
  input  logic [159:0] core_dout,
  input  logic         core_dout_vld,
  output logic [159:0] digest,
  output logic         digest_vld
);

  pad_state_t       state, state_nxt;
  logic [4:0]       wptr, wptr_nxt, wnext;
  logic [3:0]       rptr, rptr_nxt;
  logic [LEN_W-1:0] bitcnt, bitcnt_nxt;
  logic             pad80, pad80_nxt;   // 0x80000000 word still owed
  logic             lenp, lenp_nxt;     // length did not fit, goes in the next block
  logic             fin, fin_nxt;       // block in flight is the message's last
  logic             prec, prec_nxt;
  logic             run;
  logic             we, dig_ld, acc, raw_c;
  logic [31:0]      wdata, rdata;
  logic [2:0]       keep_c;
  logic [63:0]      len64;

`ifdef SHA1_PAD_RAW_EN
  logic raw;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       raw <= 1'b0;
    else if (acc && state == IDLE)   raw <= raw_mode;
  end
  assign raw_c = (state == IDLE) ? raw_mode : raw;
`else
  assign raw_c = 1'b0;
`endif

  sha1_blk_buf u_buf (
    .clk   (clk),
    .we    (we),
    .wptr  (wptr[3:0]),
    .wdata (wdata),
    .rptr  (rptr),
    .rdata (rdata)
  );

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bitcnt;
  end

  assign msg_rdy          = run & ((state == IDLE) | ((state == FILL) & ~wptr[4]));
  assign acc              = msg_vld & msg_rdy;
  assign core_din_vld     = (state == SEND);
  assign core_din         = core_din_vld ? rdata : '0;
  assign core_use_prec_cv = prec;

  // A full block waits in FILL (wptr==16, msg_rdy low) until the core is free.
  function automatic pad_state_t after_write(input logic [4:0] wn, input logic lp,
                                             input logic p80, input logic rw, input logic busy);
    if (wn[4]) return busy ? FILL : SEND;
    if (wn == 5'(SHA1_LEN_IDX) && !lp && !p80 && !rw) return LEN_HI;
    return PAD;
  endfunction

  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    rptr_nxt   = rptr;
    bitcnt_nxt = bitcnt;
    pad80_nxt  = pad80;
    lenp_nxt   = lenp;
    fin_nxt    = fin;
    prec_nxt   = prec;
    we         = 1'b0;
    wdata      = '0;
    dig_ld     = 1'b0;
    wnext      = wptr + 5'd1;
    keep_c     = (msg_keep > 3'd4) ? 3'd4 : msg_keep;
    case (state)
      IDLE, FILL: begin
        if (acc) begin
          we       = 1'b1;
          wptr_nxt = wnext;
          if (!msg_last) begin
            wdata      = msg_data;
            bitcnt_nxt = bitcnt + LEN_W'(32);
            state_nxt  = wnext[4] ? (core_busy ? FILL : SEND) : FILL;
          end else if (raw_c) begin
            wdata     = msg_data;
            fin_nxt   = 1'b1;
            state_nxt = after_write(wnext, 1'b0, 1'b0, 1'b1, core_busy);
          end else begin
            bitcnt_nxt = bitcnt + LEN_W'({keep_c, 3'b000});
            if (keep_c == 3'd4) begin
              wdata     = msg_data;
              pad80_nxt = 1'b1;
              lenp_nxt  = wnext[4];
            end else begin
              wdata    = pad_last_word(msg_data, keep_c[1:0]);
              lenp_nxt = (wptr >= 5'd14);
            end
            state_nxt = after_write(wnext, lenp_nxt, pad80_nxt, 1'b0, core_busy);
          end
        end else if (state == FILL && wptr[4] && !core_busy) begin
          state_nxt = SEND;
        end
      end
      PAD: begin
        we        = 1'b1;
        wptr_nxt  = wnext;
        pad80_nxt = 1'b0;
        wdata     = pad80 ? {SHA1_PAD_BYTE, 24'h0} : '0;
        if (pad80 && wptr >= 5'd14) lenp_nxt = 1'b1;
        state_nxt = after_write(wnext, lenp_nxt, 1'b0, raw_c, core_busy);
      end
      LEN_HI: begin
        we        = 1'b1;
        wdata     = len64[63:32];
        wptr_nxt  = wnext;
        state_nxt = LEN_LO;
      end
      LEN_LO: begin
        we        = 1'b1;
        wdata     = len64[31:0];
        wptr_nxt  = wnext;
        fin_nxt   = 1'b1;
        state_nxt = core_busy ? FILL : SEND;
      end
      SEND: begin
        rptr_nxt = rptr + 4'd1;
        if (rptr == 4'd15) state_nxt = WAIT;
      end
      WAIT: begin
        if (core_dout_vld) begin
          wptr_nxt = '0;
          if (fin) begin
            dig_ld     = 1'b1;
            state_nxt  = IDLE;
            bitcnt_nxt = '0;
            fin_nxt    = 1'b0;
            prec_nxt   = 1'b0;
          end else begin
            prec_nxt = 1'b1;
            if (lenp) begin
              lenp_nxt  = 1'b0;
              state_nxt = PAD;
            end else begin
              state_nxt = FILL;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      bitcnt     <= '0;
      pad80      <= 1'b0;
      lenp       <= 1'b0;
      fin        <= 1'b0;
      prec       <= 1'b0;
      run        <= 1'b0;
      digest     <= '0;
      digest_vld <= 1'b0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      bitcnt     <= bitcnt_nxt;
      pad80      <= pad80_nxt;
      lenp       <= lenp_nxt;
      fin        <= fin_nxt;
      prec       <= prec_nxt;
      run        <= 1'b1;
      digest_vld <= dig_ld;
      if (dig_ld) digest <= core_dout;
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: behavioural SHA-1 core on the core side, software padding
// model feeding a block-word / digest scoreboard.
module tb_sha1_msg_padder;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  logic         clk = 1'b0;
  logic         rstn;
  logic         msg_vld, msg_rdy, msg_last;
  logic [31:0]  msg_data;
  logic [2:0]   msg_keep;
  logic         core_din_vld, core_use_prec_cv, core_busy, core_dout_vld;
  logic [31:0]  core_din;
  logic [159:0] core_dout, digest;
  logic         digest_vld;

  always #5 clk = ~clk;

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk              (clk),
    .rstn             (rstn),
`ifdef SHA1_PAD_RAW_EN
    .raw_mode         (1'b0),
`endif
    .msg_vld          (msg_vld),
    .msg_rdy          (msg_rdy),
    .msg_data         (msg_data),
    .msg_last         (msg_last),
    .msg_keep         (msg_keep),
    .core_din_vld     (core_din_vld),
    .core_din         (core_din),
    .core_use_prec_cv (core_use_prec_cv),
    .core_busy        (core_busy),
    .core_dout        (core_dout),
    .core_dout_vld    (core_dout_vld),
    .digest           (digest),
    .digest_vld       (digest_vld)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   m[$];
  logic [31:0]  exp_w[$];
  logic         exp_p[$];
  logic [159:0] exp_d[$];
  logic [31:0]  cap_w0[$], cap_w15[$];
  logic         cap_p[$];
  int           dig_cnt = 0, bcnt = 0, cdown = 0, first_cyc = 0, acc_cyc = 0;
  logic [159:0] last_digest, chain, res;
  logic [511:0] blk;
  logic         burst_prec;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [159:0] sha1_comp(input logic [159:0] cv, input logic [511:0] b);
    logic [31:0] w[80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, bb, c, d, e} = cv;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = bb ^ c ^ d;                    k = 32'hCA62C1D6; end
      t  = {a[26:0], a[31:27]} + f + e + k + w[i];
      e  = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {cv[159:128] + a, cv[127:96] + bb, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
  endfunction

  // Software padding of m[] -> expected block words, chaining flags and digest.
  task automatic model_msg();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] b;
    logic [159:0] cv;
    logic [31:0]  w;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    cv = IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 16; j++) begin
        w = {p[64*bi+4*j], p[64*bi+4*j+1], p[64*bi+4*j+2], p[64*bi+4*j+3]};
        exp_w.push_back(w);
        b[511-32*j -: 32] = w;
      end
      exp_p.push_back(bi != 0);
      cv = sha1_comp(cv, b);
    end
    exp_d.push_back(cv);
  endtask

  task automatic send_msg(input bit keep_ovr, input int gap_pct);
    int n, nw, keep, budget;
    logic [31:0] w;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    keep = (n == 0) ? 0 : n - 4 * (nw - 1);
    if (keep == 4 && keep_ovr) keep = 7;
    cap_w0.delete(); cap_w15.delete(); cap_p.delete();
    @(negedge clk);
    for (int j = 0; j < nw; j++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        msg_vld = 1'b0;
        @(negedge clk);
      end
      for (int bi = 0; bi < 4; bi++) w[31-8*bi -: 8] = (4*j+bi < n) ? m[4*j+bi] : 8'hA5;
      msg_vld  = 1'b1;
      msg_data = w;
      msg_last = (j == nw - 1);
      msg_keep = (j == nw - 1) ? 3'(keep) : 3'd4;
      budget = 0;
      while (!msg_rdy && budget < 5000) begin @(negedge clk); budget++; end
      chk("msg_rdy_wait", msg_rdy, 1'b1);
      acc_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    msg_vld  = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic wait_digest();
    int budget, start;
    start  = dig_cnt - 0;
    budget = 0;
    while (dig_cnt == start && budget < 5000) begin @(negedge clk); #1; budget++; end
    chk("digest_wait", dig_cnt != start, 1'b1);
  endtask

  // Behavioural core plus output monitor.
  always @(negedge clk) begin
    if (!rstn) begin
      bcnt = 0; cdown = 0;
      core_busy = 1'b0; core_dout_vld = 1'b0; core_dout = '0;
      chain = IV;
    end else begin
      core_dout_vld = 1'b0;
      if (digest_vld) begin
        dig_cnt++;
        last_digest = digest;
        chk("digest_expected", exp_d.size() > 0, 1'b1);
        if (exp_d.size() > 0) chk("digest", digest, exp_d.pop_front());
      end
      if (bcnt > 0) chk("burst_gap", core_din_vld, 1'b1);
      if (core_din_vld) begin
        chk("vld_while_busy", core_busy, 1'b0);
        if (bcnt == 0) begin
          burst_prec = core_use_prec_cv;
          first_cyc  = cyc;
          cap_w0.push_back(core_din);
          cap_p.push_back(core_use_prec_cv);
          chk("prec_expected", exp_p.size() > 0, 1'b1);
          if (exp_p.size() > 0) chk("use_prec_cv", core_use_prec_cv, exp_p.pop_front());
        end else begin
          chk("prec_hold", core_use_prec_cv, burst_prec);
        end
        chk("din_expected", exp_w.size() > 0, 1'b1);
        if (exp_w.size() > 0) chk("core_din", core_din, exp_w.pop_front());
        blk[511-32*bcnt -: 32] = core_din;
        if (bcnt == 15) cap_w15.push_back(core_din);
        bcnt++;
        if (bcnt == 16) begin
          bcnt = 0;
          res = sha1_comp(burst_prec ? chain : IV, blk);
          chain = res;
          core_busy = 1'b1;
          cdown = 6;
        end
      end else if (cdown > 0) begin
        cdown--;
        if (cdown == 0) begin
          core_dout = res; core_dout_vld = 1'b1; core_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    string s;
    int budget;
    rstn = 1'b0; msg_vld = 1'b0; msg_data = '0; msg_last = 1'b0; msg_keep = '0;
    repeat (3) @(negedge clk);
    chk("rst_msg_rdy", msg_rdy, 1'b0);
    chk("rst_din_vld", core_din_vld, 1'b0);
    chk("rst_din", core_din, 32'h0);
    chk("rst_prec", core_use_prec_cv, 1'b0);
    chk("rst_digest", digest, 160'h0);
    chk("rst_digest_vld", digest_vld, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", msg_rdy, 1'b1);

    // Empty message, data must be ignored
    m.delete(); model_msg(); send_msg(1'b0, 0); wait_digest();
    chk("empty_digest", last_digest, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
    chk("empty_w0", cap_w0[0], 32'h80000000);
    chk("empty_w15", cap_w15[0], 32'h0);
    chk("empty_latency", first_cyc - acc_cyc, 16);

    // "abc"
    m = '{8'h61, 8'h62, 8'h63}; model_msg(); send_msg(1'b0, 0); wait_digest();
    chk("abc_digest", last_digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    chk("abc_w0", cap_w0[0], 32'h61626380);
    chk("abc_w15", cap_w15[0], 32'h00000018);
    chk("abc_latency", first_cyc - acc_cyc, 16);

    // 56 bytes: length spills into a second block
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    model_msg(); send_msg(1'b0, 0); wait_digest();
    chk("m56_digest", last_digest, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
    chk("m56_blocks", cap_w0.size(), 2);
    chk("m56_prec0", cap_p[0], 1'b0);
    chk("m56_prec1", cap_p[1], 1'b1);
    chk("m56_w15", cap_w15[1], 32'h000001C0);

    // 64 bytes, final keep given as 7 (clamped to 4)
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'(i * 7 + 3));
    model_msg(); send_msg(1'b1, 0); wait_digest();
    chk("m64_blocks", cap_w0.size(), 2);
    chk("m64_w0", cap_w0[1], 32'h80000000);
    chk("m64_w15", cap_w15[1], 32'h00000200);

    // 200 random bytes with ~50% valid gaps
    m.delete();
    for (int i = 0; i < 200; i++) m.push_back(8'($urandom));
    model_msg(); send_msg(1'b0, 50); wait_digest();
    chk("m200_blocks", cap_w0.size(), 4);

    // Reset in the middle of a burst, then "abc" again
    m = '{8'h61, 8'h62, 8'h63}; model_msg(); send_msg(1'b0, 0);
    budget = 0;
    while (bcnt != 7 && budget < 2000) begin @(negedge clk); #1; budget++; end
    chk("reach_send_w7", bcnt, 7);
    rstn = 1'b0;
    #1;
    chk("mid_rst_din_vld", core_din_vld, 1'b0);
    chk("mid_rst_din", core_din, 32'h0);
    chk("mid_rst_msg_rdy", msg_rdy, 1'b0);
    chk("mid_rst_prec", core_use_prec_cv, 1'b0);
    chk("mid_rst_digest", digest, 160'h0);
    chk("mid_rst_digest_vld", digest_vld, 1'b0);
    exp_w.delete(); exp_p.delete(); exp_d.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    m = '{8'h61, 8'h62, 8'h63}; model_msg(); send_msg(1'b0, 0); wait_digest();
    chk("abc2_digest", last_digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);

    repeat (4) @(negedge clk);
    chk("sb_words_left", exp_w.size(), 0);
    chk("sb_digests_left", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
